// File: rtl/countdown_timer_if.sv
// Button pulses into the countdown timer and the display/status signals coming back out.
interface countdown_timer_if;
  logic       set_inc;
  logic       start;
  logic       clear;
  logic [3:0] bin0;
  logic [3:0] bin1;
  logic [3:0] bin2;
  logic [3:0] bin3;
  logic       running;
  logic       expired;
  logic       expire_pulse;

  modport master (
    output set_inc, start, clear,
    input  bin0, bin1, bin2, bin3, running, expired, expire_pulse
  );

  modport slave (
    input  set_inc, start, clear,
    output bin0, bin1, bin2, bin3, running, expired, expire_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: load a start time with set_inc, start/pause/resume with start,
// decrements once per TICK_CYCLES clocks and flags expiry at 00:00.
//
// state   | meaning
// IDLE    | editing the set value, display shows set value
// RUN     | prescaler counting, count decrements on each tick
// PAUSE   | count and prescaler frozen
// EXPIRED | reached 00:00, waiting for start/clear acknowledge
module countdown_timer #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int PRE_W       = 27
) (
  input  logic          clk,
  input  logic          reset,
  countdown_timer_if.slave tmr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  logic [15:0]      s;
  logic [15:0]      c;
  logic [PRE_W-1:0] pre;
  logic             expire_pulse_q;
  logic             tick;
  logic [15:0]      disp;

  // Digit layout: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = (v[15:12] != 4'd0) ? v[15:12] - 4'd1 : 4'd5;
        end
      end
    end
    return r;
  endfunction

  assign tick = (state == RUN) && (pre == PRE_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      s              <= 16'h0000;
      c              <= 16'h0000;
      pre            <= '0;
      expire_pulse_q <= 1'b0;
    end else begin
      expire_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tmr.clear) begin
            state <= IDLE;
          end else if (tmr.start) begin
            if (s != 16'h0000) begin
              c     <= s;
              pre   <= '0;
              state <= RUN;
            end
          end else if (tmr.set_inc) begin
            s <= bcd_inc(s);
          end
        end
        RUN: begin
          // A start on the tick edge pauses and drops that tick.
          if (tmr.clear) begin
            state <= IDLE;
          end else if (tmr.start) begin
            state <= PAUSE;
          end else if (tick) begin
            pre <= '0;
            c   <= bcd_dec(c);
            if (c == 16'h0001) begin
              state          <= EXPIRED;
              expire_pulse_q <= 1'b1;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        PAUSE: begin
          if (tmr.clear)      state <= IDLE;
          else if (tmr.start) state <= RUN;
        end
        EXPIRED: begin
          if (tmr.clear || tmr.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    disp = 16'h0000;
    case (state)
      IDLE:    disp = s;
      RUN:     disp = c;
      PAUSE:   disp = c;
      EXPIRED: disp = 16'h0000;
      default: disp = 16'h0000;
    endcase
  end

  assign tmr.bin0         = disp[3:0];
  assign tmr.bin1         = disp[7:4];
  assign tmr.bin2         = disp[11:8];
  assign tmr.bin3         = disp[15:12];
  assign tmr.running      = (state == RUN);
  assign tmr.expired      = (state == EXPIRED);
  assign tmr.expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle tick; tasks start and end on a falling edge.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  countdown_timer_if tif ();

  countdown_timer #(.TICK_CYCLES(4), .PRE_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (tif)
  );

  always #5 clk = ~clk;

  wire [15:0] disp = {tif.bin3, tif.bin2, tif.bin1, tif.bin0};

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    tif.start = 1'b1;
    @(negedge clk);
    tif.start = 1'b0;
  endtask

  task automatic pulse_clear();
    tif.clear = 1'b1;
    @(negedge clk);
    tif.clear = 1'b0;
  endtask

  task automatic inc_n(input int n);
    tif.set_inc = 1'b1;
    repeat (n) @(negedge clk);
    tif.set_inc = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL reset_disp got %h want 0000", disp); end
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL reset_running got %b want 0", tif.running); end
    vectors++; if (tif.expired !== 1'b0) begin miscompares++; $display("FAIL reset_expired got %b want 0", tif.expired); end
    vectors++; if (tif.expire_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got %b want 0", tif.expire_pulse); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    reset_dut();
    inc_n(7);
    pulse_start();
    wait_cyc(2);
    vectors++; if (disp !== 16'h0007) begin miscompares++; $display("FAIL areset_pre_disp got %h want 0007", disp); end
    vectors++; if (tif.running !== 1'b1) begin miscompares++; $display("FAIL areset_pre_running got %b want 1", tif.running); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL areset_disp got %h want 0000", disp); end
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL areset_running got %b want 0", tif.running); end
    vectors++; if (tif.expired !== 1'b0) begin miscompares++; $display("FAIL areset_expired got %b want 0", tif.expired); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_set_inc();
    reset_dut();
    inc_n(75);
    vectors++; if (disp !== 16'h0115) begin miscompares++; $display("FAIL set_75 got %h want 0115", disp); end
    reset_dut();
    inc_n(3599);
    vectors++; if (disp !== 16'h5959) begin miscompares++; $display("FAIL set_3599 got %h want 5959", disp); end
    inc_n(1);
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL set_wrap got %h want 0000", disp); end
  endtask

  task automatic test_countdown_expiry();
    logic [15:0] exp_d;
    reset_dut();
    inc_n(3);
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_d = (k < 4) ? 16'h0003 : (k < 8) ? 16'h0002 : (k < 12) ? 16'h0001 : 16'h0000;
      vectors++; if (disp !== exp_d) begin miscompares++; $display("FAIL cd_disp k=%0d got %h want %h", k, disp, exp_d); end
      vectors++; if (tif.expired !== (k >= 12)) begin miscompares++; $display("FAIL cd_expired k=%0d got %b want %b", k, tif.expired, (k >= 12)); end
      vectors++; if (tif.expire_pulse !== (k == 12)) begin miscompares++; $display("FAIL cd_pulse k=%0d got %b want %b", k, tif.expire_pulse, (k == 12)); end
      vectors++; if (tif.running !== (k < 12)) begin miscompares++; $display("FAIL cd_running k=%0d got %b want %b", k, tif.running, (k < 12)); end
    end
    pulse_clear();
    vectors++; if (disp !== 16'h0003) begin miscompares++; $display("FAIL cd_clear_disp got %h want 0003", disp); end
    vectors++; if (tif.expired !== 1'b0) begin miscompares++; $display("FAIL cd_clear_expired got %b want 0", tif.expired); end
  endtask

  task automatic test_minute_borrow();
    reset_dut();
    inc_n(600);
    vectors++; if (disp !== 16'h1000) begin miscompares++; $display("FAIL set_600 got %h want 1000", disp); end
    pulse_start();
    wait_cyc(4);
    vectors++; if (disp !== 16'h0959) begin miscompares++; $display("FAIL borrow got %h want 0959", disp); end
    inc_n(1);
    wait_cyc(3);
    vectors++; if (disp !== 16'h0958) begin miscompares++; $display("FAIL borrow2 got %h want 0958", disp); end
    tif.clear = 1'b1;
    tif.start = 1'b1;
    @(negedge clk);
    tif.clear = 1'b0;
    tif.start = 1'b0;
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL clear_start_running got %b want 0", tif.running); end
    vectors++; if (disp !== 16'h1000) begin miscompares++; $display("FAIL clear_start_disp got %h want 1000", disp); end
  endtask

  task automatic test_zero_start();
    reset_dut();
    pulse_start();
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL zero_running got %b want 0", tif.running); end
    wait_cyc(5);
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL zero_running2 got %b want 0", tif.running); end
    vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL zero_disp got %h want 0000", disp); end
  endtask

  task automatic test_pause_resume();
    reset_dut();
    inc_n(2);
    pulse_start();
    wait_cyc(2);
    pulse_start();
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL pause_running got %b want 0", tif.running); end
    wait_cyc(20);
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL pause_hold got %h want 0002", disp); end
    pulse_start();
    vectors++; if (tif.running !== 1'b1) begin miscompares++; $display("FAIL resume_running got %b want 1", tif.running); end
    wait_cyc(1);
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL resume_r1 got %h want 0002", disp); end
    wait_cyc(1);
    vectors++; if (disp !== 16'h0001) begin miscompares++; $display("FAIL resume_r2 got %h want 0001", disp); end
    wait_cyc(3);
    vectors++; if (tif.expired !== 1'b0) begin miscompares++; $display("FAIL resume_early_exp got %b want 0", tif.expired); end
    wait_cyc(1);
    vectors++; if (tif.expired !== 1'b1) begin miscompares++; $display("FAIL resume_exp got %b want 1", tif.expired); end
    pulse_start();
    vectors++; if (tif.expired !== 1'b0) begin miscompares++; $display("FAIL ack_expired got %b want 0", tif.expired); end
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL ack_disp got %h want 0002", disp); end
  endtask

  task automatic test_start_on_tick();
    reset_dut();
    inc_n(2);
    pulse_start();
    wait_cyc(3);
    pulse_start();
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL tick_pause_disp got %h want 0002", disp); end
    vectors++; if (tif.running !== 1'b0) begin miscompares++; $display("FAIL tick_pause_running got %b want 0", tif.running); end
    pulse_start();
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL tick_resume_disp got %h want 0002", disp); end
    wait_cyc(1);
    vectors++; if (disp !== 16'h0001) begin miscompares++; $display("FAIL tick_resume_next got %h want 0001", disp); end
    pulse_clear();
    vectors++; if (disp !== 16'h0002) begin miscompares++; $display("FAIL tick_clear_disp got %h want 0002", disp); end
  endtask

  initial begin
    tif.set_inc = 1'b0;
    tif.start   = 1'b0;
    tif.clear   = 1'b0;
    @(negedge clk);
    test_reset();
    test_async_reset();
    test_set_inc();
    test_countdown_expiry();
    test_minute_borrow();
    test_zero_start();
    test_pause_resume();
    test_start_on_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
